// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory initiator.
// Size codes, FSM states, the captured-request record and lane-offset helpers.
package mem_access_unit_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RESP  = 2'b01,
      ST_MERGE = 2'b10
   } state_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  off;
      logic [1:0]  size;
      logic        sgn;
   } req_t;

   // The reserved size code behaves exactly like a word access.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return (size == 2'b11) ? SIZE_WORD : size;
   endfunction

   // Drop address bits finer than the access size.
   function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: return off;
         SIZE_HALF: return {off[1], 1'b0};
         default:   return 2'b00;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_BYTE: return 1'b0;
         SIZE_HALF: return off[0];
         default:   return off != 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane_align.sv
// Big-endian lane steering: extracts/extends a sub-word load and merges a sub-word store.
// Purely combinational; offset 0 is bits [31:24].
module mem_access_unit_byte_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] rd_word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        sgn,
   input  logic [31:0] wr_data,
   output logic [31:0] load_val,
   output logic [31:0] merge_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rd_word[31:24];
      case (offset)
         2'd0: byte_sel = rd_word[31:24];
         2'd1: byte_sel = rd_word[23:16];
         2'd2: byte_sel = rd_word[15:8];
         2'd3: byte_sel = rd_word[7:0];
         default: byte_sel = rd_word[31:24];
      endcase
      half_sel = offset[1] ? rd_word[15:0] : rd_word[31:16];

      load_val = rd_word;
      case (size)
         SIZE_BYTE: load_val = {{24{sgn & byte_sel[7]}}, byte_sel};
         SIZE_HALF: load_val = {{16{sgn & half_sel[15]}}, half_sel};
         default:   load_val = rd_word;
      endcase
   end

   always_comb begin
      merge_word = rd_word;
      case (size)
         SIZE_BYTE: begin
            case (offset)
               2'd0: merge_word[31:24] = wr_data[7:0];
               2'd1: merge_word[23:16] = wr_data[7:0];
               2'd2: merge_word[15:8]  = wr_data[7:0];
               2'd3: merge_word[7:0]   = wr_data[7:0];
               default: merge_word = rd_word;
            endcase
         end
         SIZE_HALF: begin
            if (offset[1]) merge_word[15:0]  = wr_data[15:0];
            else           merge_word[31:16] = wr_data[15:0];
         end
         default: merge_word = wr_data;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: word store in 1 cycle, loads and sub-word stores (read-modify-write) in 2.
// StallM holds the pipeline for the first cycle of 2-cycle ops; MISALIGN_TRAP_EN enables the misalign trap.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ReqM,
   input  logic              MemWriteM,
   input  logic [1:0]        SizeM,
   input  logic              SignedM,
   input  logic [ADDR_W-1:0] ALUOutM,
   input  logic [DATA_W-1:0] WriteDataM,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWD,
   output logic              MemWE,
   output logic              MemRE,
   input  logic [DATA_W-1:0] MemRD,
   output logic [DATA_W-1:0] ReadDataM,
   output logic              StallM,
   output logic              DoneM,
   output logic              MisalignM
);

   state_t              state_q, state_d;
   logic [ADDR_W-3:0]   word_addr_q, word_addr_d;
   req_t                req_q, req_d;

   logic [1:0]          size_n, off_n;
   logic                we_c, re_c, stall_c, done_c, mis_c;
   logic [ADDR_W-1:0]   addr_c;
   logic [DATA_W-1:0]   wd_c, rdata_c;
   logic [31:0]         load_val, merge_word;

   assign size_n = norm_size(SizeM);
   assign off_n  = align_offset(size_n, ALUOutM[1:0]);

   mem_access_unit_byte_lane_align u_lane (
      .rd_word    (MemRD),
      .offset     (req_q.off),
      .size       (req_q.size),
      .sgn        (req_q.sgn),
      .wr_data    (req_q.data),
      .load_val   (load_val),
      .merge_word (merge_word)
   );

   always_comb begin
      state_d     = state_q;
      word_addr_d = word_addr_q;
      req_d       = req_q;
      we_c        = 1'b0;
      re_c        = 1'b0;
      stall_c     = 1'b0;
      done_c      = 1'b0;
      mis_c       = 1'b0;
      addr_c      = '0;
      wd_c        = '0;
      rdata_c     = '0;

      case (state_q)
         ST_IDLE: begin
            if (ReqM) begin
`ifdef MISALIGN_TRAP_EN
               if (is_misaligned(size_n, ALUOutM[1:0])) begin
                  mis_c  = 1'b1;
                  done_c = 1'b1;
               end else
`endif
               if (MemWriteM && size_n == SIZE_WORD) begin
                  addr_c = {ALUOutM[ADDR_W-1:2], 2'b00};
                  we_c   = 1'b1;
                  wd_c   = WriteDataM;
                  done_c = 1'b1;
               end else begin
                  // Loads and sub-word stores both need the current word first.
                  addr_c      = {ALUOutM[ADDR_W-1:2], 2'b00};
                  re_c        = 1'b1;
                  stall_c     = 1'b1;
                  word_addr_d = ALUOutM[ADDR_W-1:2];
                  req_d.data  = WriteDataM;
                  req_d.off   = off_n;
                  req_d.size  = size_n;
                  req_d.sgn   = SignedM;
                  state_d     = MemWriteM ? ST_MERGE : ST_RESP;
               end
            end
         end
         ST_RESP: begin
            addr_c  = {word_addr_q, 2'b00};
            rdata_c = load_val;
            done_c  = 1'b1;
            state_d = ST_IDLE;
         end
         ST_MERGE: begin
            addr_c  = {word_addr_q, 2'b00};
            wd_c    = merge_word;
            we_c    = 1'b1;
            done_c  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         word_addr_q <= '0;
         req_q       <= '0;
      end else begin
         state_q     <= state_d;
         word_addr_q <= word_addr_d;
         req_q       <= req_d;
      end
   end

   // Reset overrides everything so an abandoned MERGE never writes.
   assign MemWE     = we_c & ~RST;
   assign MemRE     = re_c & ~RST;
   assign StallM    = stall_c & ~RST;
   assign DoneM     = done_c & ~RST;
   assign MemAddr   = RST ? '0 : addr_c;
   assign MemWD     = RST ? '0 : wd_c;
   assign ReadDataM = RST ? '0 : rdata_c;
`ifdef MISALIGN_TRAP_EN
   assign MisalignM = mis_c & ~RST;
`else
   assign MisalignM = 1'b0 & mis_c;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against a sync-read word memory model.
module tb_mem_access_unit;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        ReqM = 1'b0;
   logic        MemWriteM = 1'b0;
   logic [1:0]  SizeM = 2'b10;
   logic        SignedM = 1'b0;
   logic [31:0] ALUOutM = '0;
   logic [31:0] WriteDataM = '0;
   logic [31:0] MemAddr, MemWD, MemRD, ReadDataM;
   logic        MemWE, MemRE, StallM, DoneM, MisalignM;

   int passed = 0;
   int total  = 0;

   always #5 CLK = ~CLK;

   mem_access_unit dut (
      .CLK(CLK), .RST(RST), .ReqM(ReqM), .MemWriteM(MemWriteM), .SizeM(SizeM),
      .SignedM(SignedM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
      .MemAddr(MemAddr), .MemWD(MemWD), .MemWE(MemWE), .MemRE(MemRE), .MemRD(MemRD),
      .ReadDataM(ReadDataM), .StallM(StallM), .DoneM(DoneM), .MisalignM(MisalignM)
   );

   logic [31:0] mem [0:255];
   always @(posedge CLK) begin
      if (MemWE) mem[MemAddr[9:2]] <= MemWD;
      MemRD <= mem[MemAddr[9:2]];
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          exp_stall;
      logic [31:0] exp_rd;
      logic        exp_mis;
      logic [31:0] exp_mem;
   } vec_t;

   vec_t vecs [20];
   vec_t sb_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
      else passed++;
   endtask

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata, input int st,
                               input logic [31:0] rd, input logic mis, input logic [31:0] m);
      vec_t v;
      v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
      v.exp_stall = st; v.exp_rd = rd; v.exp_mis = mis; v.exp_mem = m;
      return v;
   endfunction

   // Drives one request and holds it until DoneM; leaves the bench 1 time unit after the completing edge.
   task automatic do_req(input vec_t v, input int idx);
      vec_t e;
      int   stalls = 0;
      bit   got = 0;
      ReqM = 1'b1; MemWriteM = v.we; SizeM = v.size; SignedM = v.sgn;
      ALUOutM = v.addr; WriteDataM = v.wdata;
      sb_q.push_back(v);
      for (int c = 0; c < 8 && !got; c++) begin
         @(negedge CLK);
         if (DoneM) begin
            got = 1;
            e = sb_q.pop_front();
            chk($sformatf("v%0d stall_cycles", idx), 32'(stalls), 32'(e.exp_stall));
            chk($sformatf("v%0d misalign", idx), {31'd0, MisalignM}, {31'd0, e.exp_mis});
            if (!e.we || e.exp_mis) chk($sformatf("v%0d read_data", idx), ReadDataM, e.exp_rd);
         end else if (StallM) begin
            stalls++;
         end
         @(posedge CLK);
         #1;
      end
      if (!got) begin
         chk($sformatf("v%0d done_timeout", idx), 32'd0, 32'd1);
         void'(sb_q.pop_front());
      end else if (v.we) begin
         chk($sformatf("v%0d mem_word", idx), mem[v.addr[9:2]], v.exp_mem);
      end
   endtask

   initial begin
      vecs[0]  = mk(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 0, 32'h0, 0, 32'hDEADBEEF);
      vecs[1]  = mk(0, 2'b10, 0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0, 32'h0);
      vecs[2]  = mk(1, 2'b10, 0, 32'h100, 32'h80FF7F01, 0, 32'h0, 0, 32'h80FF7F01);
      vecs[3]  = mk(0, 2'b00, 1, 32'h100, 32'h0, 1, 32'hFFFFFF80, 0, 32'h0);
      vecs[4]  = mk(0, 2'b00, 0, 32'h101, 32'h0, 1, 32'h000000FF, 0, 32'h0);
      vecs[5]  = mk(0, 2'b00, 1, 32'h102, 32'h0, 1, 32'h0000007F, 0, 32'h0);
      vecs[6]  = mk(0, 2'b01, 1, 32'h102, 32'h0, 1, 32'h00007F01, 0, 32'h0);
      vecs[7]  = mk(0, 2'b01, 0, 32'h100, 32'h0, 1, 32'h000080FF, 0, 32'h0);
      vecs[8]  = mk(0, 2'b01, 1, 32'h100, 32'h0, 1, 32'hFFFF80FF, 0, 32'h0);
      vecs[9]  = mk(0, 2'b00, 1, 32'h103, 32'h0, 1, 32'h00000001, 0, 32'h0);
      vecs[10] = mk(0, 2'b11, 0, 32'h100, 32'h0, 1, 32'h80FF7F01, 0, 32'h0);
`ifdef MISALIGN_TRAP_EN
      vecs[11] = mk(0, 2'b10, 0, 32'h102, 32'h0, 0, 32'h0, 1, 32'h0);
`else
      vecs[11] = mk(0, 2'b10, 0, 32'h102, 32'h0, 1, 32'h80FF7F01, 0, 32'h0);
`endif
      vecs[12] = mk(1, 2'b10, 0, 32'h104, 32'h11223344, 0, 32'h0, 0, 32'h11223344);
      vecs[13] = mk(1, 2'b00, 0, 32'h105, 32'hFFFFFFAB, 1, 32'h0, 0, 32'h11AB3344);
      vecs[14] = mk(1, 2'b10, 0, 32'h104, 32'h11223344, 0, 32'h0, 0, 32'h11223344);
      vecs[15] = mk(1, 2'b01, 0, 32'h106, 32'h1234CAFE, 1, 32'h0, 0, 32'h1122CAFE);
      vecs[16] = mk(1, 2'b10, 0, 32'h200, 32'h55667788, 0, 32'h0, 0, 32'h55667788);
      vecs[17] = mk(1, 2'b00, 0, 32'h200, 32'h00000099, 1, 32'h0, 0, 32'h99667788);
      vecs[18] = mk(0, 2'b10, 0, 32'h200, 32'h0, 1, 32'h99667788, 0, 32'h0);
`ifdef MISALIGN_TRAP_EN
      vecs[19] = mk(1, 2'b01, 0, 32'h201, 32'h0000BEEF, 0, 32'h0, 1, 32'h99667788);
`else
      vecs[19] = mk(1, 2'b01, 0, 32'h201, 32'h0000BEEF, 1, 32'h0, 0, 32'hBEEF7788);
`endif

      // Reset dominates even with a word store presented.
      ReqM = 1'b1; MemWriteM = 1'b1; SizeM = 2'b10; ALUOutM = 32'h100; WriteDataM = 32'h12345678;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst MemWE", {31'd0, MemWE}, 32'd0);
      chk("rst MemRE", {31'd0, MemRE}, 32'd0);
      chk("rst StallM", {31'd0, StallM}, 32'd0);
      chk("rst DoneM", {31'd0, DoneM}, 32'd0);
      chk("rst ReadDataM", ReadDataM, 32'd0);
      chk("rst MisalignM", {31'd0, MisalignM}, 32'd0);
      @(posedge CLK);
      #1;
      RST = 1'b0;

      // Table runs back to back with no idle cycle between requests.
      for (int i = 0; i < 20; i++) do_req(vecs[i], i);
      ReqM = 1'b0;
      chk("scoreboard empty", 32'(sb_q.size()), 32'd0);

      // Reset in the MERGE cycle must abandon the write.
      do_req(mk(1, 2'b10, 0, 32'h300, 32'h11223344, 0, 32'h0, 0, 32'h11223344), 20);
      ReqM = 1'b1; MemWriteM = 1'b1; SizeM = 2'b00; ALUOutM = 32'h301; WriteDataM = 32'hAB;
      @(negedge CLK);
      chk("rmw first StallM", {31'd0, StallM}, 32'd1);
      chk("rmw first MemRE", {31'd0, MemRE}, 32'd1);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      @(negedge CLK);
      chk("rst merge MemWE", {31'd0, MemWE}, 32'd0);
      chk("rst merge DoneM", {31'd0, DoneM}, 32'd0);
      @(posedge CLK);
      #1;
      chk("rst merge mem", mem[8'hC0], 32'h11223344);
      RST = 1'b0;
      ReqM = 1'b0;
      @(negedge CLK);
      chk("post rst StallM", {31'd0, StallM}, 32'd0);
      chk("post rst DoneM", {31'd0, DoneM}, 32'd0);
      chk("post rst MemWE", {31'd0, MemWE}, 32'd0);
      chk("post rst MemAddr", MemAddr, 32'd0);
      chk("post rst ReadDataM", ReadDataM, 32'd0);
      @(posedge CLK);
      #1;
      // Single-cycle completion proves the FSM came back in IDLE.
      do_req(mk(1, 2'b10, 0, 32'h300, 32'hA5A5A5A5, 0, 32'h0, 0, 32'hA5A5A5A5), 21);
      ReqM = 1'b0;
      repeat (2) @(posedge CLK);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
